// File: rtl/red_pkg.sv
// Shared widths, state encoding and sign-extension helpers for the nibble reduction unit.
package red_pkg;

    localparam int NIBBLES = 4;
    localparam int NIB_W   = 4;
    localparam int ACC_W   = 8;
    localparam int WORD_W  = 16;
    localparam int PAIR_W  = NIB_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Widen a signed nibble to the 5-bit adder operand width.
    function automatic logic [PAIR_W-1:0] sext5(input logic [NIB_W-1:0] nib);
        return {nib[NIB_W-1], nib};
    endfunction

    // Widen a 5-bit pair sum to the accumulator width.
    function automatic logic [ACC_W-1:0] sext_acc(input logic [PAIR_W-1:0] val);
        return {{(ACC_W-PAIR_W){val[PAIR_W-1]}}, val};
    endfunction

endpackage

// File: rtl/red_unit_cla.sv
// Existing 5-bit carry-lookahead adder: every carry is formed directly from generate/propagate terms.
module CLA_5bit (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       cin,
    output logic [4:0] sum,
    output logic       cout
);

    logic [4:0] g;
    logic [4:0] p;
    logic [5:0] c;

    // Flattened lookahead carries so no carry waits on the previous stage.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
             | (p[4] & p[3] & p[2] & g[1]) | (p[4] & p[3] & p[2] & p[1] & g[0])
             | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[4:0];
        cout = c[5];
    end

endmodule

// File: rtl/red_unit.sv
// Sums four signed nibble pairs from two 16-bit operands, one pair per cycle, into a sign-extended word.
module red_unit
    import red_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] rs_data,
    input  logic [WORD_W-1:0] rt_data,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result
);

    state_t             state;
    state_t             next_state;
    logic [WORD_W-1:0]  op_a;
    logic [WORD_W-1:0]  op_b;
    logic [ACC_W-1:0]   acc;
    logic [1:0]         cnt;
    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [PAIR_W-1:0]  pair_sum;
    logic [ACC_W-1:0]   acc_next;
    logic               carry_unused;
    logic               accept;

    // A new request is only honoured while not accumulating, so start during ACCUM is ignored.
    assign accept = start && (state == IDLE || state == DONE);

    // Nibble pair selected by the counter, least significant nibble first.
    assign nib_a = op_a[{cnt, 2'b00} +: NIB_W];
    assign nib_b = op_b[{cnt, 2'b00} +: NIB_W];

    CLA_5bit u_pair_add (
        .a    (sext5(nib_a)),
        .b    (sext5(nib_b)),
        .cin  (1'b0),
        .sum  (pair_sum),
        .cout (carry_unused)
    );

    assign acc_next = acc + sext_acc(pair_sum);

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: four ACCUM cycles, then a single DONE cycle that may chain straight into a new run.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ACCUM;
            ACCUM:   if (cnt == 2'd3) next_state = DONE;
            DONE:    next_state = accept ? ACCUM : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, accumulation and result update; result only moves on the final accumulate edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            op_a <= rs_data;
            op_b <= rt_data;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == ACCUM) begin
            acc <= acc_next;
            if (cnt == 2'd3) begin
                result <= {{(WORD_W-ACC_W){acc_next[ACC_W-1]}}, acc_next};
            end else begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    assign busy = (state == ACCUM);
    assign done = (state == DONE);

endmodule

// File: tb/tb_red_unit.sv
// Directed bench for red_unit: a vector table of single operations plus hand-built overlap and reset sequences.
module tb_red_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] exp_result;
    } vec_t;

    vec_t vecs[8];

    red_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for done; returns the number of falling edges it took.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Caller is at a falling edge; issues one request and checks the full busy/done/result timeline.
    task automatic apply_stimulus(input string name, input logic [15:0] rs, input logic [15:0] rt,
                                  input logic [15:0] exp_result);
        int cycles;
        rs_data = rs;
        rt_data = rt;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        rs_data = 16'($urandom);
        rt_data = 16'($urandom);
        check_output({name, " busy_after_start"}, {15'd0, busy}, 16'd1);
        check_output({name, " done_after_start"}, {15'd0, done}, 16'd0);
        wait_done(cycles);
        check_output({name, " done_latency"}, 16'(cycles), 16'd4);
        check_output({name, " busy_in_done"}, {15'd0, busy}, 16'd0);
        check_output({name, " result"}, result, exp_result);
        @(negedge clk);
        check_output({name, " done_pulse_end"}, {15'd0, done}, 16'd0);
        check_output({name, " result_hold"}, result, exp_result);
    endtask

    initial begin
        int cycles;

        vecs[0] = '{16'h1234, 16'h1111, 16'h000E};
        vecs[1] = '{16'h8888, 16'h8888, 16'hFFC0};
        vecs[2] = '{16'h7777, 16'h7777, 16'h0038};
        vecs[3] = '{16'h0001, 16'h0001, 16'h0002};
        vecs[4] = '{16'hF000, 16'h0000, 16'hFFFF};
        vecs[5] = '{16'h0000, 16'h0000, 16'h0000};
        vecs[6] = '{16'h1234, 16'hFFFF, 16'h0006};
        vecs[7] = '{16'h7F08, 16'h0080, 16'hFFF6};

        rst_n   = 1'b0;
        start   = 1'b0;
        rs_data = 16'h0;
        rt_data = 16'h0;
        #12;
        check_output("reset busy", {15'd0, busy}, 16'd0);
        check_output("reset done", {15'd0, done}, 16'd0);
        check_output("reset result", result, 16'h0000);

        // Release reset on a falling edge and request on the very next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].rs, vecs[i].rt, vecs[i].exp_result);
        end

        // start held through ACCUM with new operands must be ignored.
        rs_data = 16'h1234;
        rt_data = 16'h1111;
        start   = 1'b1;
        @(negedge clk);
        rs_data = 16'hFFFF;
        rt_data = 16'hFFFF;
        @(negedge clk);
        check_output("ignore busy_e1", {15'd0, busy}, 16'd1);
        @(negedge clk);
        check_output("ignore busy_e2", {15'd0, busy}, 16'd1);
        @(negedge clk);
        start = 1'b0;
        check_output("ignore busy_e3", {15'd0, busy}, 16'd1);
        @(negedge clk);
        check_output("ignore done", {15'd0, done}, 16'd1);
        check_output("ignore result", result, 16'h000E);
        @(negedge clk);
        check_output("ignore no_restart busy", {15'd0, busy}, 16'd0);
        check_output("ignore single_done", {15'd0, done}, 16'd0);

        // Reset during the second ACCUM cycle abandons the run.
        rs_data = 16'h7777;
        rt_data = 16'h7777;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midreset busy", {15'd0, busy}, 16'd0);
        check_output("midreset done", {15'd0, done}, 16'd0);
        check_output("midreset result", result, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("midreset no_done", {15'd0, done}, 16'd0);
        end
        rst_n = 1'b1;
        apply_stimulus("after_reset", 16'h0001, 16'h0001, 16'h0002);

        // Back-to-back: start held across DONE launches the next run on the DONE edge.
        rs_data = 16'h1234;
        rt_data = 16'h1111;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rs_data = 16'hF000;
        rt_data = 16'h0000;
        start   = 1'b1;
        @(negedge clk);
        check_output("b2b first_done", {15'd0, done}, 16'd1);
        check_output("b2b first_result", result, 16'h000E);
        @(negedge clk);
        start = 1'b0;
        check_output("b2b restart busy", {15'd0, busy}, 16'd1);
        check_output("b2b restart done", {15'd0, done}, 16'd0);
        check_output("b2b result_hold", result, 16'h000E);
        wait_done(cycles);
        check_output("b2b second_latency", 16'(cycles), 16'd4);
        check_output("b2b second_result", result, 16'hFFFF);
        @(negedge clk);
        check_output("b2b idle", {15'd0, busy | done}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
